// File: rtl/edge_generator_pkg.sv
// Shared command/state encodings for edge_generator.
package edge_generator_pkg;

  typedef enum logic [1:0] {
    CMD_FALL   = 2'b00,
    CMD_RISE   = 2'b01,
    CMD_PULSE  = 2'b10,
    CMD_TOGGLE = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_HOLD  = 2'b01,
    S_PULSE = 2'b10
  } state_e;

  // Level a command drives o_signal to (PULSE reports its inverted phase).
  function automatic logic target_level(input cmd_e cmd, input logic cur);
    case (cmd)
      CMD_FALL: target_level = 1'b0;
      CMD_RISE: target_level = 1'b1;
      default:  target_level = ~cur;
    endcase
  endfunction

endpackage

// File: rtl/edge_generator.sv
// Programmable edge/pulse source with per-level minimum hold width.
// Optional EDGE_GEN_COUNT_EN adds a 16-bit transition counter output o_edge_cnt.
module edge_generator
  import edge_generator_pkg::*;
#(
  parameter int   HOLD_W        = 8,
  parameter logic DEFAULT_LEVEL = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [1:0]        i_cmd,
  input  logic [HOLD_W-1:0] i_hold,
  output logic              o_signal,
  output logic              o_busy,
  output logic              o_done
`ifdef EDGE_GEN_COUNT_EN
  ,
  output logic [15:0]       o_edge_cnt
`endif
);

  state_e            state_q, state_d;
  logic              sig_q, sig_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic              done_q, done_d;
  cmd_e              cmd;
  logic              tgt;

  assign cmd = cmd_e'(i_cmd);
  assign tgt = target_level(cmd, sig_q);

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          if (cmd == CMD_PULSE || tgt != sig_q) begin
            sig_d   = tgt;
            state_d = (cmd == CMD_PULSE) ? S_PULSE : S_HOLD;
            // Hold of 0 behaves as 1; the counter holds W-1 so the state lasts W cycles.
            cnt_d   = (i_hold == '0) ? '0 : i_hold - HOLD_W'(1);
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_HOLD, S_PULSE: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          if (state_q == S_PULSE) sig_d = ~sig_q;
        end else begin
          cnt_d = cnt_q - HOLD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      sig_q   <= DEFAULT_LEVEL;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign o_ready  = (state_q == S_IDLE);
  assign o_busy   = ~o_ready;
  assign o_signal = sig_q;
  assign o_done   = done_q;

`ifdef EDGE_GEN_COUNT_EN
  logic [15:0] edge_cnt_q, edge_cnt_d;

  always_comb edge_cnt_d = (sig_d != sig_q) ? edge_cnt_q + 16'd1 : edge_cnt_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) edge_cnt_q <= '0;
    else         edge_cnt_q <= edge_cnt_d;
  end

  assign o_edge_cnt = edge_cnt_q;
`endif

endmodule

// File: tb/tb_edge_generator.sv
// Self-checking bench for edge_generator: directed scenarios plus randomized commands vs a level/timeline model.
module tb_edge_generator;
  import edge_generator_pkg::*;

  localparam int HOLD_W = 8;

  logic              i_clk = 1'b0;
  logic              i_reset;
  logic              i_valid;
  logic [1:0]        i_cmd;
  logic [HOLD_W-1:0] i_hold;
  logic              o_ready, o_signal, o_busy, o_done;
`ifdef EDGE_GEN_COUNT_EN
  logic [15:0]       o_edge_cnt;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 i_clk = ~i_clk;

  edge_generator #(.HOLD_W(HOLD_W), .DEFAULT_LEVEL(1'b0)) dut (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_cmd    (i_cmd),
    .i_hold   (i_hold),
    .o_signal (o_signal),
    .o_busy   (o_busy),
    .o_done   (o_done)
`ifdef EDGE_GEN_COUNT_EN
    ,
    .o_edge_cnt (o_edge_cnt)
`endif
  );

  // Outputs packed as {signal, ready, busy, done}.
  function automatic logic [3:0] obs();
    return {o_signal, o_ready, o_busy, o_done};
  endfunction

  task automatic test_reset();
    i_reset = 1'b1; i_valid = 1'b0; i_cmd = 2'b00; i_hold = '0;
    #1;
    n_total++;
    if (obs() !== 4'b0100) $display("FAIL reset_state: got %b expected 0100", obs());
    else n_pass++;
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
    @(negedge i_clk);
    n_total++;
    if (obs() !== 4'b0100) $display("FAIL reset_release: got %b expected 0100", obs());
    else n_pass++;
  endtask

  task automatic test_pulse_min();
    i_valid = 1'b1; i_cmd = CMD_PULSE; i_hold = '0;
    @(posedge i_clk); @(negedge i_clk);
    i_valid = 1'b0;
    n_total++;
    if (obs() !== 4'b1010) $display("FAIL pulse0_t1: got %b expected 1010", obs());
    else n_pass++;
    @(negedge i_clk);
    n_total++;
    if (obs() !== 4'b0101) $display("FAIL pulse0_t2: got %b expected 0101", obs());
    else n_pass++;
    @(negedge i_clk);
    n_total++;
    if (obs() !== 4'b0100) $display("FAIL pulse0_t3: got %b expected 0100", obs());
    else n_pass++;
  endtask

  task automatic test_rise_hold();
    i_valid = 1'b1; i_cmd = CMD_RISE; i_hold = 8'd3;
    @(posedge i_clk); @(negedge i_clk);
    i_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) @(negedge i_clk);
      n_total++;
      if (obs() !== 4'b1010) $display("FAIL rise3_t%0d: got %b expected 1010", k, obs());
      else n_pass++;
    end
    @(negedge i_clk);
    n_total++;
    if (obs() !== 4'b1101) $display("FAIL rise3_t4: got %b expected 1101", obs());
    else n_pass++;
  endtask

  task automatic test_no_edge();
    int dropped;
    dropped = 0;
    i_valid = 1'b1; i_cmd = CMD_RISE; i_hold = 8'd4;
    @(posedge i_clk); @(negedge i_clk);
    i_valid = 1'b0;
    n_total++;
    if (obs() !== 4'b1101) $display("FAIL noedge_t1: got %b expected 1101", obs());
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      if (o_ready !== 1'b1 || o_signal !== 1'b1 || o_done !== 1'b0) dropped++;
    end
    n_total++;
    if (dropped !== 0) $display("FAIL noedge_after: got %0d bad cycles expected 0", dropped);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    // FALL W=2, then TOGGLE presented from T+1 must wait until the done cycle.
    i_valid = 1'b1; i_cmd = CMD_FALL; i_hold = 8'd2;
    @(posedge i_clk); @(negedge i_clk);
    i_cmd = CMD_TOGGLE;
    n_total++;
    if (obs() !== 4'b0010) $display("FAIL b2b_t1: got %b expected 0010", obs());
    else n_pass++;
    @(negedge i_clk);
    n_total++;
    if (obs() !== 4'b0010) $display("FAIL b2b_t2: got %b expected 0010", obs());
    else n_pass++;
    @(negedge i_clk);
    n_total++;
    if (obs() !== 4'b0101) $display("FAIL b2b_t3: got %b expected 0101", obs());
    else n_pass++;
    @(negedge i_clk);
    i_valid = 1'b0;
    n_total++;
    if (obs() !== 4'b1010) $display("FAIL b2b_t4: got %b expected 1010", obs());
    else n_pass++;
    @(negedge i_clk);
    @(negedge i_clk);
    n_total++;
    if (obs() !== 4'b1101) $display("FAIL b2b_t6: got %b expected 1101", obs());
    else n_pass++;
  endtask

  task automatic test_reset_abort();
    int dones;
    dones = 0;
    // Bring level to 0 first so the pulse phase differs from the reset level.
    i_valid = 1'b1; i_cmd = CMD_FALL; i_hold = '0;
    @(posedge i_clk); @(negedge i_clk);
    i_valid = 1'b0;
    @(negedge i_clk);
    i_valid = 1'b1; i_cmd = CMD_PULSE; i_hold = 8'd5;
    @(posedge i_clk); @(negedge i_clk);
    i_valid = 1'b0;
    @(negedge i_clk);
    n_total++;
    if (obs() !== 4'b1010) $display("FAIL abort_pre: got %b expected 1010", obs());
    else n_pass++;
    i_reset = 1'b1;
    #1;
    n_total++;
    if (obs() !== 4'b0100) $display("FAIL abort_async: got %b expected 0100", obs());
    else n_pass++;
    @(negedge i_clk);
    i_reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge i_clk);
      if (o_done !== 1'b0 || o_ready !== 1'b1 || o_signal !== 1'b0) dones++;
    end
    n_total++;
    if (dones !== 0) $display("FAIL abort_after: got %0d bad cycles expected 0", dones);
    else n_pass++;
  endtask

  task automatic test_random();
    logic       lvl, tgt, fin, edge_cmd;
    logic [1:0] cmd;
    logic [HOLD_W-1:0] hold;
    int         w, nc, gap;
    logic [3:0] exp_o;
    lvl = o_signal;
    for (int n = 0; n < 60; n++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(negedge i_clk);
        n_total++;
        if (obs() !== {lvl, 3'b100}) $display("FAIL rnd_idle%0d: got %b expected %b", n, obs(), {lvl, 3'b100});
        else n_pass++;
      end
      cmd  = 2'($urandom_range(0, 3));
      hold = ($urandom_range(0, 3) == 0) ? '0 : HOLD_W'($urandom_range(1, 6));
      w    = (hold == 0) ? 1 : int'(hold);
      case (cmd)
        2'b00:   tgt = 1'b0;
        2'b01:   tgt = 1'b1;
        default: tgt = ~lvl;
      endcase
      edge_cmd = (tgt != lvl);
      fin      = (cmd == 2'b10) ? lvl : tgt;
      nc       = edge_cmd ? w + 1 : 1;
      i_valid = 1'b1; i_cmd = cmd; i_hold = hold;
      @(posedge i_clk); @(negedge i_clk);
      i_valid = 1'b0;
      for (int k = 1; k <= nc; k++) begin
        if (k > 1) @(negedge i_clk);
        exp_o = (k == nc) ? {fin, 3'b101} : {tgt, 3'b010};
        n_total++;
        if (obs() !== exp_o)
          $display("FAIL rnd_cmd%0d_c%0d: got %b expected %b (cmd=%b hold=%0d)", n, k, obs(), exp_o, cmd, hold);
        else n_pass++;
      end
      lvl = fin;
    end
    @(negedge i_clk);
  endtask

`ifdef EDGE_GEN_COUNT_EN
  task automatic test_edge_cnt();
    logic [1:0] seq_cmd [3];
    seq_cmd[0] = CMD_RISE; seq_cmd[1] = CMD_PULSE; seq_cmd[2] = CMD_FALL;
    i_reset = 1'b1;
    @(negedge i_clk);
    i_reset = 1'b0;
    n_total++;
    if (o_edge_cnt !== 16'd0) $display("FAIL cnt_reset: got %0d expected 0", o_edge_cnt);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      i_valid = 1'b1; i_cmd = seq_cmd[i]; i_hold = 8'd1;
      @(posedge i_clk); @(negedge i_clk);
      i_valid = 1'b0;
      for (int t = 0; t < 40 && !o_done; t++) @(negedge i_clk);
      @(negedge i_clk);
    end
    n_total++;
    if (o_edge_cnt !== 16'd4) $display("FAIL cnt_seq: got %0d expected 4", o_edge_cnt);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_pulse_min();
    test_rise_hold();
    test_no_edge();
    test_back_to_back();
    test_reset_abort();
    test_random();
`ifdef EDGE_GEN_COUNT_EN
    test_edge_cnt();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
